// File: rtl/montgomery_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier: FSM encoding,
// counter sizing and the DIGIT legality rule.
package montgomery_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOOP, S_SUB, S_DONE} state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic bit digit_legal(input int w, input int d);
        return ((d == 1) || (d == 2) || (d == 4) || (d == 8)) && ((w % d) == 0);
    endfunction

endpackage

// File: rtl/mont_step.sv
// One combinational radix-2 Montgomery step: C' = (C + a_bit*b [+ m]) / 2.
module mont_step #(
    parameter int WIDTH = 1024
) (
    input  logic [WIDTH+1:0] c_i,
    input  logic             a_bit_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH+1:0] c_o
);

    logic [WIDTH+1:0] sum_ab;
    logic [WIDTH+1:0] sum_m;

    // With C < 2m and b < m the sum stays below 4m, so WIDTH+2 bits never overflow.
    assign sum_ab = c_i + (a_bit_i ? {2'b00, b_i} : '0);
    assign sum_m  = sum_ab[0] ? (sum_ab + {2'b00, m_i}) : sum_ab;
    assign c_o    = {1'b0, sum_m[WIDTH+1:1]};

endmodule

// File: rtl/montgomery_mult_param.sv
// Parametrised radix-2 Montgomery multiplier, result = a*b*2^-WIDTH mod m,
// DIGIT steps per clock, final conditional subtract so the result is < m.
module montgomery_mult_param
    import montgomery_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    if (!digit_legal(WIDTH, DIGIT)) begin : g_bad_digit
        $error("montgomery_mult_param: DIGIT must be 1,2,4,8 and divide WIDTH");
    end

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, m_q;
    logic [WIDTH+1:0]   c_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [DIGIT:0][WIDTH+1:0] chain;
    assign chain[0] = c_q;

    for (genvar g = 0; g < DIGIT; g++) begin : g_step
        mont_step #(.WIDTH(WIDTH)) u_step (
            .c_i    (chain[g]),
            .a_bit_i(a_q[g]),
            .b_i    (b_q),
            .m_i    (m_q),
            .c_o    (chain[g+1])
        );
    end

    // C < 2m < 2^(WIDTH+1), so the compare/subtract only needs WIDTH+1 bits.
    logic [WIDTH:0]   c_lo, diff;
    logic             ge;
    logic [WIDTH-1:0] res_d;
    logic             unused_bits;

    assign c_lo        = c_q[WIDTH:0];
    assign diff        = c_lo - {1'b0, m_q};
    assign ge          = c_lo >= {1'b0, m_q};
    assign res_d       = ge ? diff[WIDTH-1:0] : c_lo[WIDTH-1:0];
    assign unused_bits = ^{c_q[WIDTH+1], diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            result  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        m_q   <= in_m;
                        c_q   <= '0;
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        err   <= ~in_m[0];
                        if (!in_m[0]) begin
                            result  <= '0;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_LOOP;
                        end
                    end
                end
                S_LOOP: begin
                    c_q   <= chain[DIGIT];
                    a_q   <= a_q >> DIGIT;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= S_SUB;
                end
                S_SUB: begin
                    result  <= res_d;
                    done    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // Normal path arrives with done already set; the even-modulus
                    // path arrives with done clear and raises it here first.
                    if (done) begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Directed bench for montgomery_mult_param: three instances (W4/D1, W4/D2, W16/D4).
module tb_montgomery_mult_param;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  start;
    logic [15:0] ina [3];
    logic [15:0] inb [3];
    logic [15:0] inm [3];
    logic [3:0]  r0, r1;
    logic [15:0] r2;
    logic [2:0]  done, busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    montgomery_mult_param #(.WIDTH(4), .DIGIT(1)) dut0 (
        .clk(clk), .resetn(resetn), .start(start[0]),
        .in_a(ina[0][3:0]), .in_b(inb[0][3:0]), .in_m(inm[0][3:0]),
        .result(r0), .done(done[0]), .busy(busy[0]), .err(err[0]));

    montgomery_mult_param #(.WIDTH(4), .DIGIT(2)) dut1 (
        .clk(clk), .resetn(resetn), .start(start[1]),
        .in_a(ina[1][3:0]), .in_b(inb[1][3:0]), .in_m(inm[1][3:0]),
        .result(r1), .done(done[1]), .busy(busy[1]), .err(err[1]));

    montgomery_mult_param #(.WIDTH(16), .DIGIT(4)) dut2 (
        .clk(clk), .resetn(resetn), .start(start[2]),
        .in_a(ina[2]), .in_b(inb[2]), .in_m(inm[2]),
        .result(r2), .done(done[2]), .busy(busy[2]), .err(err[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] get_res(input int id);
        case (id)
            0:       return {12'h0, r0};
            1:       return {12'h0, r1};
            default: return r2;
        endcase
    endfunction

    // Reference by search: the x in [0,m) with x*2^w == a*b (mod m).
    function automatic logic [15:0] ref_mont(input longint a, input longint b,
                                              input longint m, input int w);
        longint target;
        target = (a * b) % m;
        for (longint x = 0; x < m; x++)
            if (((x << w) % m) == target) return x[15:0];
        return 16'hffff;
    endfunction

    // Called at a negedge; returns at the negedge inside the done cycle.
    task automatic run(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] m, input logic [15:0] exp_r, input logic exp_e,
                       input int exp_lat, input bit repulse, input string tag);
        int lat;
        ina[id] = a; inb[id] = b; inm[id] = m;
        start[id] = 1'b1;
        @(negedge clk);
        lat = 1;
        if (repulse) begin
            ina[id] = 16'h1; inb[id] = 16'h1; inm[id] = 16'h4;
        end else begin
            start[id] = 1'b0;
        end
        chk({tag, "_busy"}, busy[id], 1'b1);
        while (!done[id] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        start[id] = 1'b0;
        chk({tag, "_done"}, done[id], 1'b1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, get_res(id), exp_r);
        chk({tag, "_err"}, err[id], exp_e);
    endtask

    task automatic post(input int id, input string tag);
        @(negedge clk);
        chk({tag, "_done_low"}, done[id], 1'b0);
        chk({tag, "_busy_low"}, busy[id], 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        logic [15:0] va, vb, vm;
        resetn = 1'b0;
        start  = '0;
        for (int i = 0; i < 3; i++) begin
            ina[i] = '0; inb[i] = '0; inm[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_result", r0, 4'd0);
        chk("rst_done", done, 3'b000);
        chk("rst_busy", busy, 3'b000);
        chk("rst_err", err, 3'b000);
        chk("rst_result2", r2, 16'd0);
        resetn = 1'b1;
        @(negedge clk);

        run(0, 7, 9, 13, 8, 1'b0, 6, 1'b0, "t1"); post(0, "t1");
        run(1, 1, 1, 13, 9, 1'b0, 4, 1'b0, "t2a"); post(1, "t2a");
        run(1, 12, 12, 13, 9, 1'b0, 4, 1'b0, "t2b"); post(1, "t2b");
        run(0, 5, 5, 12, 0, 1'b1, 2, 1'b0, "t3"); post(0, "t3");
        run(1, 5, 5, 12, 0, 1'b1, 2, 1'b0, "t3d2"); post(1, "t3d2");

        run(0, 7, 9, 13, 8, 1'b0, 6, 1'b1, "t4"); post(0, "t4");
        run(0, 0, 9, 13, 0, 1'b0, 6, 1'b0, "t4b2b"); post(0, "t4b2b");

        run(0, 12, 12, 13, 9, 1'b0, 6, 1'b0, "t5pre"); post(0, "t5pre");
        ina[0] = 7; inb[0] = 9; inm[0] = 13; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("t5_rst_result", r0, 4'd0);
        chk("t5_rst_done", done[0], 1'b0);
        chk("t5_rst_busy", busy[0], 1'b0);
        chk("t5_rst_err", err[0], 1'b0);
        resetn = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done[0]) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        run(0, 7, 9, 13, 8, 1'b0, 6, 1'b0, "t5post"); post(0, "t5post");

        run(2, 16'd12345, 16'd54321, 16'd65521, ref_mont(12345, 54321, 65521, 16),
            1'b0, 6, 1'b0, "t6a"); post(2, "t6a");
        run(2, 16'd40960, 16'd40960, 16'd40961, ref_mont(40960, 40960, 40961, 16),
            1'b0, 6, 1'b0, "t6b"); post(2, "t6b");
        run(2, 16'd65534, 16'd1, 16'd65535, ref_mont(65534, 1, 65535, 16),
            1'b0, 6, 1'b0, "t6c"); post(2, "t6c");
        run(2, 16'd0, 16'd0, 16'd1, 16'd0, 1'b0, 6, 1'b0, "t6m1"); post(2, "t6m1");
        for (int k = 0; k < 4; k++) begin
            vm = 16'($urandom_range(3, 65535)) | 16'd1;
            va = 16'($urandom_range(0, 65535) % vm);
            vb = 16'($urandom_range(0, 65535) % vm);
            run(2, va, vb, vm, ref_mont(va, vb, vm, 16), 1'b0, 6, 1'b0, "t6rand");
            post(2, "t6rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
